// File: rtl/imem_wr_arbiter.sv
// Round-robin arbiter sharing the instruction-memory write port among the cores.
// One core owns the port per grant for up to MAX_BURST beats; priority then rotates.
module imem_wr_arbiter #(
  parameter int unsigned N_CORES   = 4,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned IDX_W    = (N_CORES > 1) ? $clog2(N_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_CORES-1:0]          req,
  input  logic [N_CORES*ADDR_W-1:0]   wr_addr,
  input  logic [N_CORES*DATA_W-1:0]   wr_data,
  output logic [N_CORES-1:0]          gnt,
  output logic [IDX_W-1:0]            gnt_id,
  output logic                        busy,
  output logic                        im_we,
  output logic [ADDR_W-1:0]           im_addr,
  output logic [DATA_W-1:0]           im_wdata
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [N_CORES-1:0]   gnt_q, gnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    data_q, data_d;

  logic [IDX_W-1:0]     cand;
  logic [IDX_W-1:0]     win;
  logic                 found;

  // Rotating priority scan: first requester at or after ptr wins
  always_comb begin
    cand  = '0;
    win   = ptr_q;
    found = 1'b0;
    for (int unsigned k = 0; k < N_CORES; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % N_CORES);
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        gnt_d = '0;
        if (found) begin
          owner_d = win;
          cnt_d   = '0;
          state_d = GRANT;
          gnt_d   = N_CORES'(1) << win;
        end
      end
      GRANT: begin
        if (req[owner_q]) begin
          we_d   = 1'b1;
          addr_d = wr_addr[32'(owner_q)*ADDR_W +: ADDR_W];
          data_d = wr_data[32'(owner_q)*DATA_W +: DATA_W];
          cnt_d  = cnt_q + CNT_W'(1);
        end
        // Release on dropped request or on the last beat of the burst
        if (!req[owner_q] || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = (owner_q == IDX_W'(N_CORES - 1)) ? '0 : owner_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign gnt      = gnt_q;
  assign gnt_id   = owner_q;
  assign busy     = (state_q == GRANT);
  assign im_we    = we_q;
  assign im_addr  = addr_q;
  assign im_wdata = data_q;

endmodule

// File: tb/tb_imem_wr_arbiter.sv
// Directed bench for imem_wr_arbiter: grant timing, burst cap, rotation, reset, early release.
module tb_imem_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [15:0] im_wdata;

  int n_cmp  = 0;
  int n_fail = 0;

  imem_wr_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr_addr(wr_addr), .wr_data(wr_data),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .im_we(im_we),
    .im_addr(im_addr), .im_wdata(im_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    req     = 4'b1111;
    wr_addr = 32'hDEADBEEF;
    wr_data = 64'h0123456789ABCDEF;
    tick();
    tick();
    n_cmp++;
    if ({gnt, gnt_id, busy, im_we, im_addr, im_wdata} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got gnt=%b id=%0d busy=%b we=%b addr=%h data=%h want all zero",
               gnt, gnt_id, busy, im_we, im_addr, im_wdata);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    req = 4'b0010;
    wr_addr[8 +: 8]   = 8'h10;
    wr_data[16 +: 16] = 16'h1234;
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || im_we !== 1'b0 || busy !== 1'b1 || gnt_id !== 2'd1) begin
      n_fail++;
      $display("FAIL t1_grant: got gnt=%b we=%b busy=%b id=%0d want 0010 0 1 1", gnt, im_we, busy, gnt_id);
    end
    tick();
    n_cmp++;
    if (im_we !== 1'b1 || im_addr !== 8'h10 || im_wdata !== 16'h1234) begin
      n_fail++;
      $display("FAIL t1_beat1: got we=%b %h:%h want 1 10:1234", im_we, im_addr, im_wdata);
    end
    wr_addr[8 +: 8]   = 8'h11;
    wr_data[16 +: 16] = 16'h5678;
    tick();
    n_cmp++;
    if (im_we !== 1'b1 || im_addr !== 8'h11 || im_wdata !== 16'h5678) begin
      n_fail++;
      $display("FAIL t1_beat2: got we=%b %h:%h want 1 11:5678", im_we, im_addr, im_wdata);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || im_we !== 1'b0 || busy !== 1'b0 || im_addr !== 8'h11) begin
      n_fail++;
      $display("FAIL t1_release: got gnt=%b we=%b busy=%b addr=%h want 0000 0 0 11", gnt, im_we, busy, im_addr);
    end
    // ptr now 2: among cores 0,1,2 core 2 wins
    req = 4'b0111;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      n_fail++;
      $display("FAIL t1_ptr: got gnt=%b id=%0d want 0100 2", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_burst_cap();
    logic [13:0] exp_we;
    logic [13:0] exp_gnt;
    int          writes;
    do_reset();
    // bit k = expected value after edge k+1
    exp_we  = 14'b01101111011110;
    exp_gnt = 14'b01110111101111;
    writes  = 0;
    req = 4'b0001;
    wr_addr[0 +: 8] = 8'h00;
    for (int k = 0; k < 14; k++) begin
      if (k == 13) req = 4'b0000;
      tick();
      n_cmp++;
      if (im_we !== exp_we[k] || gnt[0] !== exp_gnt[k]) begin
        n_fail++;
        $display("FAIL t2_cycle%0d: got we=%b gnt0=%b want %b %b", k + 1, im_we, gnt[0], exp_we[k], exp_gnt[k]);
      end
      if (im_we === 1'b1) begin
        n_cmp++;
        if (im_addr !== 8'(writes)) begin
          n_fail++;
          $display("FAIL t2_addr: got %h want %h", im_addr, 8'(writes));
        end
        writes++;
        wr_addr[0 +: 8] = 8'(writes);
      end
    end
    n_cmp++;
    if (writes !== 10) begin
      n_fail++;
      $display("FAIL t2_total: got %0d writes want 10", writes);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] core;
    rst_n = 1'b0;
    req   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wr_addr[i*8 +: 8]   = 8'(8'h40 + i);
      wr_data[i*16 +: 16] = 16'(16'hA000 + i);
    end
    tick();
    rst_n = 1'b1;
    for (int g = 0; g < 5; g++) begin
      core = 2'(g % 4);
      for (int c = 0; c < 5; c++) begin
        tick();
        if (c == 0) begin
          n_cmp++;
          if (gnt !== (4'b0001 << core) || gnt_id !== core || im_we !== 1'b0) begin
            n_fail++;
            $display("FAIL t3_grant%0d: got gnt=%b id=%0d we=%b want core %0d", g, gnt, gnt_id, im_we, core);
          end
        end else begin
          n_cmp++;
          if (im_we !== 1'b1 || im_addr !== 8'(8'h40 + core) || im_wdata !== 16'(16'hA000 + core)) begin
            n_fail++;
            $display("FAIL t3_beat%0d_%0d: got we=%b %h:%h want core %0d", g, c, im_we, im_addr, im_wdata, core);
          end
          n_cmp++;
          if (gnt !== ((c == 4) ? 4'b0000 : (4'b0001 << core))) begin
            n_fail++;
            $display("FAIL t3_gnt%0d_%0d: got %b core %0d", g, c, gnt, core);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    for (int i = 0; i < 4; i++) wr_addr[i*8 +: 8] = 8'(8'h20 + i);
    // short grant for core 2 leaves ptr at 3
    req = 4'b0100;
    tick();
    tick();
    req = 4'b0000;
    tick();
    req = 4'b0100;
    tick();
    tick();
    tick();
    n_cmp++;
    if (im_we !== 1'b1 || im_addr !== 8'h22) begin
      n_fail++;
      $display("FAIL t4_beat2: got we=%b addr=%h want 1 22", im_we, im_addr);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (gnt !== 4'b0000 || im_we !== 1'b0 || busy !== 1'b0 || im_addr !== 8'h00) begin
      n_fail++;
      $display("FAIL t4_async: got gnt=%b we=%b busy=%b addr=%h want 0 0 0 00", gnt, im_we, busy, im_addr);
    end
    tick();
    tick();
    n_cmp++;
    if (im_we !== 1'b0 || gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL t4_held: got we=%b gnt=%b want 0 0000", im_we, gnt);
    end
    req = 4'b1100;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      n_fail++;
      $display("FAIL t4_regrant: got gnt=%b id=%0d want 0100 2", gnt, gnt_id);
    end
    tick();
    n_cmp++;
    if (im_we !== 1'b1 || im_addr !== 8'h22) begin
      n_fail++;
      $display("FAIL t4_after: got we=%b addr=%h want 1 22", im_we, im_addr);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_drop_mid_grant();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_addr[i*8 +: 8]   = 8'(8'h30 + i);
      wr_data[i*16 +: 16] = 16'(16'hC000 + i);
    end
    req = 4'b1000;
    tick();
    n_cmp++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      n_fail++;
      $display("FAIL t5_grant: got gnt=%b id=%0d want 1000 3", gnt, gnt_id);
    end
    req = 4'b1011;
    tick();
    n_cmp++;
    if (im_we !== 1'b1 || im_addr !== 8'h33 || im_wdata !== 16'hC003) begin
      n_fail++;
      $display("FAIL t5_beat: got we=%b %h:%h want 1 33:c003", im_we, im_addr, im_wdata);
    end
    req = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || im_we !== 1'b0 || im_addr !== 8'h33) begin
      n_fail++;
      $display("FAIL t5_release: got gnt=%b we=%b addr=%h want 0000 0 33", gnt, im_we, im_addr);
    end
    // ptr wrapped to 0: core 0 beats core 1
    req = 4'b0011;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0 || im_we !== 1'b0) begin
      n_fail++;
      $display("FAIL t5_ptr: got gnt=%b id=%0d we=%b want 0001 0 0", gnt, gnt_id, im_we);
    end
    req = 4'b0000;
    tick();
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    wr_addr = '0;
    wr_data = '0;
    test_reset();
    test_single();
    test_burst_cap();
    test_round_robin();
    test_reset_mid_burst();
    test_drop_mid_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
